// File: rtl/pc_con_pila.sv
// ============================================================================
// Module      : pc_con_pila
// Description : Fetch-stage program counter with an internal incrementer,
//               branch/jump redirect and a circular return-address stack
//               with full/empty flags and a sticky overflow/underflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_con_pila #(
  parameter int ANCHO_PC     = 11,
  parameter int PROF_PILA    = 4,
  parameter int VECTOR_RESET = 0,
  parameter int INCREMENTO   = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable_pc,
  input  logic                           salto,
  input  logic                           llamada,
  input  logic                           retorno,
  input  logic [ANCHO_PC-1:0]            destino_salto,
  output logic [ANCHO_PC-1:0]            pc_actual,
  output logic [ANCHO_PC-1:0]            pc_secuencial,
  output logic                           pila_vacia,
  output logic                           pila_llena,
  output logic [$clog2(PROF_PILA):0]     profundidad,
  output logic                           desborde
);

  // Pointer width; the pointer indexes the next free slot and wraps modulo
  // PROF_PILA, which makes a push on a full stack overwrite the oldest entry.
  localparam int PW = $clog2(PROF_PILA);

  localparam logic [ANCHO_PC-1:0] C_VECTOR_RESET = ANCHO_PC'(VECTOR_RESET);
  localparam logic [ANCHO_PC-1:0] C_INCREMENTO   = ANCHO_PC'(INCREMENTO);
  localparam logic [PW:0]         C_LLENA        = (PW+1)'(PROF_PILA);
  localparam logic [PW-1:0]       C_UNO_SP       = PW'(1);
  localparam logic [PW:0]         C_UNO_CNT      = (PW+1)'(1);

  logic [ANCHO_PC-1:0] pc_q, pc_d;
  logic [PW-1:0]       sp_q, sp_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [ANCHO_PC-1:0] pila_q [PROF_PILA];

  logic [ANCHO_PC-1:0] sec;
  logic [PW-1:0]       tope_idx;
  logic                vacia;
  logic                llena;
  logic                push;

  assign sec      = pc_q + C_INCREMENTO;
  assign tope_idx = sp_q - C_UNO_SP;
  assign vacia    = (cnt_q == '0);
  assign llena    = (cnt_q == C_LLENA);

  // Next-state selection: retorno > llamada > salto > sequential, all gated by enable_pc.
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    push  = 1'b0;
    if (enable_pc) begin
      if (retorno) begin
        if (!vacia) begin
          pc_d  = pila_q[tope_idx];
          sp_d  = tope_idx;
          cnt_d = cnt_q - C_UNO_CNT;
        end else begin
          pc_d  = sec;
          ovf_d = 1'b1;
        end
      end else if (llamada) begin
        pc_d = destino_salto;
        push = 1'b1;
        sp_d = sp_q + C_UNO_SP;
        if (llena) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + C_UNO_CNT;
        end
      end else if (salto) begin
        pc_d = destino_salto;
      end else begin
        pc_d = sec;
      end
    end
  end

  // PC, stack pointer, entry count and sticky overflow registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= C_VECTOR_RESET;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Return-address storage; contents need no reset, only the write is gated.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      pila_q[sp_q] <= sec;
    end
  end

  assign pc_actual     = pc_q;
  assign pc_secuencial = sec;
  assign pila_vacia    = vacia;
  assign pila_llena    = llena;
  assign profundidad   = cnt_q;
  assign desborde      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_con_pila.sv
// ============================================================================
// Module      : tb_pc_con_pila
// Description : Self-checking bench for pc_con_pila: a queue-based reference
//               model checked every cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_con_pila;

  localparam int ANCHO_PC  = 11;
  localparam int PROF_PILA = 4;

  logic                clock;
  logic                reset;
  logic                enable_pc;
  logic                salto;
  logic                llamada;
  logic                retorno;
  logic [ANCHO_PC-1:0] destino_salto;
  logic [ANCHO_PC-1:0] pc_actual;
  logic [ANCHO_PC-1:0] pc_secuencial;
  logic                pila_vacia;
  logic                pila_llena;
  logic [2:0]          profundidad;
  logic                desborde;

  int checks   = 0;
  int failures = 0;

  pc_con_pila #(
    .ANCHO_PC     (ANCHO_PC),
    .PROF_PILA    (PROF_PILA),
    .VECTOR_RESET (0),
    .INCREMENTO   (1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_pc     (enable_pc),
    .salto         (salto),
    .llamada       (llamada),
    .retorno       (retorno),
    .destino_salto (destino_salto),
    .pc_actual     (pc_actual),
    .pc_secuencial (pc_secuencial),
    .pila_vacia    (pila_vacia),
    .pila_llena    (pila_llena),
    .profundidad   (profundidad),
    .desborde      (desborde)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stack is a queue holding at most PROF_PILA return
  // addresses, newest at the back; pushing onto a full queue drops the front.
  int unsigned         m_pc;
  int unsigned         m_stk[$];
  bit                  m_ovf;
  bit                  m_valid = 1'b0;

  always @(posedge clock) begin
    int unsigned seq;
    if (reset) begin
      m_pc    = 0;
      m_stk   = {};
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid && enable_pc) begin
      seq = (m_pc + 1) % (1 << ANCHO_PC);
      if (retorno) begin
        if (m_stk.size() > 0) begin
          m_pc = m_stk.pop_back();
        end else begin
          m_pc  = seq;
          m_ovf = 1'b1;
        end
      end else if (llamada) begin
        if (m_stk.size() == PROF_PILA) begin
          void'(m_stk.pop_front());
          m_ovf = 1'b1;
        end
        m_stk.push_back(seq);
        m_pc = destino_salto;
      end else if (salto) begin
        m_pc = destino_salto;
      end else begin
        m_pc = seq;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_pc_actual", pc_actual, m_pc);
      chk("model_pc_secuencial", pc_secuencial, (m_pc + 1) % (1 << ANCHO_PC));
      chk("model_profundidad", profundidad, m_stk.size());
      chk("model_pila_vacia", pila_vacia, m_stk.size() == 0);
      chk("model_pila_llena", pila_llena, m_stk.size() == PROF_PILA);
      chk("model_desborde", desborde, m_ovf);
    end
  end

  // One clock step with the given controls; returns #1 after the edge.
  task automatic step(input logic en, input logic s, input logic l, input logic r,
                      input logic [ANCHO_PC-1:0] d);
    enable_pc     = en;
    salto         = s;
    llamada       = l;
    retorno       = r;
    destino_salto = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable_pc = 1'b0; salto = 1'b0; llamada = 1'b0; retorno = 1'b0;
    destino_salto = '0;
    @(posedge clock); #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
    reset = 1'b0;
    chk("reset_pc", pc_actual, 32'h000);
    chk("reset_prof", profundidad, 0);
    chk("reset_vacia", pila_vacia, 1);
    chk("reset_llena", pila_llena, 0);
    chk("reset_desborde", desborde, 0);

    // Sequential counting and wrap.
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
      chk("seq_pc", pc_actual, i);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 11'h7FF);
    chk("salto_7ff", pc_actual, 32'h7FF);
    chk("sec_wrap", pc_secuencial, 32'h000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
    chk("wrap_pc", pc_actual, 32'h000);

    // Stall ignores all redirects.
    step(1'b1, 1'b1, 1'b0, 1'b0, 11'h005);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 11'h100);
      chk("stall_pc", pc_actual, 32'h005);
      chk("stall_prof", profundidad, 0);
    end

    // Call and return.
    step(1'b1, 1'b0, 1'b1, 1'b0, 11'h040);
    chk("call_pc", pc_actual, 32'h040);
    chk("call_prof", profundidad, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 11'h000);
    chk("ret_pc", pc_actual, 32'h006);
    chk("ret_prof", profundidad, 0);
    chk("ret_vacia", pila_vacia, 1);
    chk("ret_desborde", desborde, 0);

    // Overflow and underflow.
    step(1'b1, 1'b1, 1'b0, 1'b0, 11'h010);
    for (int i = 2; i <= 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 11'(i * 16));
    chk("ovf_pc", pc_actual, 32'h060);
    chk("ovf_prof", profundidad, 4);
    chk("ovf_llena", pila_llena, 1);
    chk("ovf_desborde", desborde, 1);
    for (int i = 5; i >= 2; i--) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 11'h000);
      chk("pop_pc", pc_actual, i * 16 + 1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 11'h000);
    chk("underflow_pc", pc_actual, 32'h022);
    chk("underflow_prof", profundidad, 0);
    chk("underflow_desborde", desborde, 1);

    // Priority: retorno beats llamada and salto.
    step(1'b1, 1'b1, 1'b0, 1'b0, 11'h030);
    step(1'b1, 1'b0, 1'b1, 1'b0, 11'h100);
    chk("prio_setup_prof", profundidad, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 11'h200);
    chk("prio_ret_pc", pc_actual, 32'h031);
    chk("prio_ret_prof", profundidad, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 11'h300);
    chk("prio_call_pc", pc_actual, 32'h300);
    chk("prio_call_prof", profundidad, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 11'h000);
    chk("prio_call_ret", pc_actual, 32'h032);

    // Reset mid-operation with stalled PC.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 11'h080);
    chk("midrst_pre_prof", profundidad, 3);
    chk("midrst_pre_desborde", desborde, 1);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
    reset = 1'b0;
    chk("midrst_pc", pc_actual, 32'h000);
    chk("midrst_prof", profundidad, 0);
    chk("midrst_vacia", pila_vacia, 1);
    chk("midrst_desborde", desborde, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
    chk("post_rst_pc", pc_actual, 32'h001);

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
